mc_sequencer: RTL and testbench

Parametrised multicycle control sequencer for the MIPS core. It replaces the fixed five-state stage-enable FSM and drives one-hot stage enables (fetch/decode/execute/memory/writeback plus `m_or_e`) to the existing stage modules. It adds a ready/req handshake to instruction and data memory, class-dependent stage skipping, a watchdog timeout, halt/resume, and performance counters. It sits between the decoder (instruction class in) and the stage registers, regfile and memory ports.

---
 rtl/pipes.sv | 39 +++
 rtl/mc_perf_counters.sv | 31 +++
 rtl/mc_sequencer.sv | 149 ++++++++++++++
 tb/tb_mc_sequencer.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipes.sv
// rtl/pipes.sv - shared types for the multicycle control sequencer
package pipes;

    typedef enum logic [2:0] {
        MC_ALU    = 3'd0,
        MC_LOAD   = 3'd1,
        MC_STORE  = 3'd2,
        MC_BRANCH = 3'd3,
        MC_JUMP   = 3'd4
    } mc_class_t;

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_FETCH,
        ST_DECODE,
        ST_EXECUTE,
        ST_MEMORY,
        ST_WRITEBACK,
        ST_HALT,
        ST_ERROR
    } mc_state_t;

    typedef struct packed {
        logic fetch_enable;
        logic decode_enable;
        logic execute_enable;
        logic memory_enable;
        logic writeback_enable;
        logic m_or_e;
    } state_enable_t;

    localparam int MC_WAIT_W = 16;

    // Encodings 5..7 are reserved by the decoder and never valid
    function automatic logic class_legal(input mc_class_t c);
        return 3'(c) <= 3'(MC_JUMP);
    endfunction

endpackage

// File: rtl/mc_perf_counters.sv
// rtl/mc_perf_counters.sv - retire, active-cycle and stall counters
module mc_perf_counters #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             retire,
    input  logic             stall,
    input  logic             active,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retire_cnt <= '0;
            cycle_cnt  <= '0;
            stall_cnt  <= '0;
        end else begin
            if (retire)
                retire_cnt <= retire_cnt + CNT_W'(1);
            if (active)
                cycle_cnt <= cycle_cnt + CNT_W'(1);
            // Stall count saturates so long waits never look like few waits
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mc_sequencer.sv
// rtl/mc_sequencer.sv - multicycle stage sequencer with memory handshake and watchdog
module mc_sequencer
    import pipes::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  mc_class_t        instr_class,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    input  logic             halt_req,
    input  logic             resume,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output state_enable_t    state_enable,
    output logic             retire,
    output logic             halted,
    output logic             err,
    output logic [CNT_W-1:0] retire_cnt,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [MC_WAIT_W-1:0] WAIT_LAST = MC_WAIT_W'(TIMEOUT - 1);

    mc_state_t            state, state_d, ret_state;
    mc_class_t            class_q;
    logic                 m_or_e_q;
    logic [MC_WAIT_W-1:0] wait_cnt;
    logic                 stall, active, timeout;

    // wait_cnt holds the number of earlier consecutive wait cycles in this stage
    assign timeout   = (wait_cnt == WAIT_LAST);
    assign ret_state = halt_req ? ST_HALT : ST_FETCH;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_BOOT;
            class_q  <= MC_ALU;
            m_or_e_q <= 1'b0;
            wait_cnt <= '0;
        end else begin
            state <= state_d;
            if (state == ST_DECODE)
                class_q <= instr_class;
            if (state == ST_EXECUTE)
                m_or_e_q <= (class_q == MC_LOAD);
            wait_cnt <= stall ? wait_cnt + MC_WAIT_W'(1) : '0;
        end
    end

    always_comb begin
        state_d      = state;
        imem_req     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        state_enable = '0;
        retire       = 1'b0;
        halted       = 1'b0;
        err          = 1'b0;
        stall        = 1'b0;
        active       = 1'b0;
        state_enable.m_or_e = m_or_e_q && (state != ST_ERROR);
        case (state)
            ST_BOOT: state_d = ST_FETCH;
            ST_FETCH: begin
                active   = 1'b1;
                imem_req = 1'b1;
                if (imem_ready) begin
                    state_enable.fetch_enable = 1'b1;
                    state_d = ST_DECODE;
                end else begin
                    stall = 1'b1;
                    if (timeout)
                        state_d = ST_ERROR;
                end
            end
            ST_DECODE: begin
                active = 1'b1;
                state_enable.decode_enable = 1'b1;
                if (!class_legal(instr_class)) begin
                    state_d = ST_ERROR;
                end else if (instr_class == MC_JUMP) begin
                    retire  = 1'b1;
                    state_d = ret_state;
                end else begin
                    state_d = ST_EXECUTE;
                end
            end
            ST_EXECUTE: begin
                active = 1'b1;
                state_enable.execute_enable = 1'b1;
                case (class_q)
                    MC_BRANCH: begin
                        retire  = 1'b1;
                        state_d = ret_state;
                    end
                    MC_LOAD, MC_STORE: state_d = ST_MEMORY;
                    default:           state_d = ST_WRITEBACK;
                endcase
            end
            ST_MEMORY: begin
                active   = 1'b1;
                dmem_req = 1'b1;
                dmem_we  = (class_q == MC_STORE);
                if (dmem_ready) begin
                    state_enable.memory_enable = 1'b1;
                    if (class_q == MC_STORE) begin
                        retire  = 1'b1;
                        state_d = ret_state;
                    end else begin
                        state_d = ST_WRITEBACK;
                    end
                end else begin
                    stall = 1'b1;
                    if (timeout)
                        state_d = ST_ERROR;
                end
            end
            ST_WRITEBACK: begin
                active  = 1'b1;
                state_enable.writeback_enable = 1'b1;
                retire  = 1'b1;
                state_d = ret_state;
            end
            ST_HALT: begin
                halted = 1'b1;
                if (resume)
                    state_d = ST_FETCH;
            end
            default: err = 1'b1;
        endcase
    end

    mc_perf_counters #(.CNT_W(CNT_W)) u_perf (
        .clk        (clk),
        .reset      (reset),
        .retire     (retire),
        .stall      (stall),
        .active     (active),
        .retire_cnt (retire_cnt),
        .cycle_cnt  (cycle_cnt),
        .stall_cnt  (stall_cnt)
    );

endmodule

// File: tb/tb_mc_sequencer.sv
// tb/tb_mc_sequencer.sv - randomized self-checking bench for mc_sequencer
module tb_mc_sequencer;
    import pipes::*;

    localparam int CNT_W   = 8;
    localparam int TIMEOUT = 4;
    localparam int CMAX    = (1 << CNT_W) - 1;
    localparam int S_F = 0, S_D = 1, S_E = 2, S_M = 3, S_W = 4;

    logic clk = 1'b0;
    logic reset = 1'b0;
    mc_class_t instr_class = MC_ALU;
    logic imem_ready = 1'b0, dmem_ready = 1'b0, halt_req = 1'b0, resume = 1'b0;
    logic imem_req, dmem_req, dmem_we, retire, halted, err;
    state_enable_t state_enable;
    logic [CNT_W-1:0] retire_cnt, cycle_cnt, stall_cnt;

    always #5 clk = ~clk;

    mc_sequencer #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk          (clk),
        .reset        (reset),
        .instr_class  (instr_class),
        .imem_ready   (imem_ready),
        .dmem_ready   (dmem_ready),
        .halt_req     (halt_req),
        .resume       (resume),
        .imem_req     (imem_req),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .state_enable (state_enable),
        .retire       (retire),
        .halted       (halted),
        .err          (err),
        .retire_cnt   (retire_cnt),
        .cycle_cnt    (cycle_cnt),
        .stall_cnt    (stall_cnt)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Instruction-level model: the stage list an instruction walks through
    bit m_boot, m_halt, m_err, m_moe;
    int plan[$];
    int idx, m_cls, m_wait, m_cyc, m_ret, m_stall;

    int ret_log[$];
    int we_log[$];
    int n_dreq;
    logic [5:0] en_log [0:63];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic set_plan(input int c);
        case (c)
            0:       plan = {S_F, S_D, S_E, S_W};
            1:       plan = {S_F, S_D, S_E, S_M, S_W};
            2:       plan = {S_F, S_D, S_E, S_M};
            3:       plan = {S_F, S_D, S_E};
            default: plan = {S_F, S_D};
        endcase
    endtask

    task automatic new_instr();
        plan = {S_F, S_D};
        idx = 0;
        m_wait = 0;
    endtask

    task automatic model_reset();
        m_boot = 1; m_halt = 0; m_err = 0; m_moe = 0;
        plan = {}; idx = 0; m_cls = 0; m_wait = 0;
        m_cyc = 0; m_ret = 0; m_stall = 0;
        ret_log = {}; we_log = {}; n_dreq = 0;
    endtask

    function automatic logic [11:0] dut_ctrl();
        return {imem_req, dmem_req, dmem_we, retire, halted, err, state_enable};
    endfunction

    task automatic step(input bit ir, input bit dr, input int cls, input bit hq, input bit rs);
        logic [11:0] e;
        bit done, fin, run, bad;
        int s;
        @(negedge clk);
        imem_ready = ir; dmem_ready = dr; halt_req = hq; resume = rs;
        instr_class = mc_class_t'(cls[2:0]);
        #1;
        e = '0; done = 0; fin = 0; run = 0; bad = 0; s = -1;
        if (m_boot) begin
        end else if (m_err) begin
            e[6] = 1'b1;
        end else if (m_halt) begin
            e[7] = 1'b1;
            e[0] = m_moe;
        end else begin
            run = 1;
            s = plan[idx];
            e[0] = m_moe;
            case (s)
                S_F: begin e[11] = 1'b1; done = ir; end
                S_M: begin e[10] = 1'b1; e[9] = (m_cls == 2); done = dr; end
                default: done = 1;
            endcase
            if (s == S_D) begin
                m_cls = cls;
                if (cls > 4) bad = 1;
                else set_plan(cls);
            end
            if (done) e[5 - s] = 1'b1;
            fin = done && !bad && (idx == plan.size() - 1);
            e[8] = fin;
        end
        chk("ctrl", 32'(dut_ctrl()), 32'(e));
        chk("retire_cnt", 32'(retire_cnt), 32'(m_ret));
        chk("cycle_cnt", 32'(cycle_cnt), 32'(m_cyc));
        chk("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        if (retire) ret_log.push_back(cyc);
        if (dmem_we) we_log.push_back(cyc);
        if (dmem_req) n_dreq++;
        en_log[cyc % 64] = state_enable;

        if (run) m_cyc = (m_cyc + 1) % (CMAX + 1);
        if (m_boot) begin
            m_boot = 0;
            new_instr();
        end else if (m_halt) begin
            if (rs) begin m_halt = 0; new_instr(); end
        end else if (!m_err) begin
            if (!done) begin
                m_stall = (m_stall == CMAX) ? CMAX : m_stall + 1;
                m_wait++;
                if (m_wait == TIMEOUT) m_err = 1;
            end else begin
                m_wait = 0;
                if (bad) m_err = 1;
                else begin
                    if (s == S_E) m_moe = (m_cls == 1);
                    if (fin) begin
                        m_ret = (m_ret + 1) % (CMAX + 1);
                        if (hq) m_halt = 1;
                        else new_instr();
                    end else idx++;
                end
            end
        end
        cyc++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        imem_ready = 0; dmem_ready = 0; halt_req = 0; resume = 0;
        model_reset();
        @(posedge clk);
        #2;
        chk("reset_outputs", {dut_ctrl(), retire_cnt, cycle_cnt, stall_cnt}, 32'd0);
        reset = 1'b1;
        cyc = 0;
    endtask

    // Asserts reset between clock edges; outputs must clear without a clock
    task automatic async_reset_now();
        #1;
        reset = 1'b0;
        #1;
        chk("async_reset_outputs", {dut_ctrl(), retire_cnt, cycle_cnt, stall_cnt}, 32'd0);
        model_reset();
        @(posedge clk);
        #2;
        reset = 1'b1;
        cyc = 0;
    endtask

    initial begin
        model_reset();

        // ALU, readies high
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("alu_fetch_en", 32'(en_log[1]), 32'b100000);
        chk("alu_decode_en", 32'(en_log[2]), 32'b010000);
        chk("alu_execute_en", 32'(en_log[3]), 32'b001000);
        chk("alu_writeback_en", 32'(en_log[4]), 32'b000010);
        chk("alu_retire_cycle", (ret_log.size() > 0) ? ret_log[0] : -1, 4);
        chk("alu_retire_cnt", 32'(retire_cnt), 1);

        // LOAD with three data-memory wait cycles
        do_reset();
        for (int i = 0; i < 9; i++) step(1, !(i >= 4 && i <= 6), 1, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("load_dmem_req_cycles", n_dreq, 4);
        chk("load_dmem_we_count", we_log.size(), 0);
        chk("load_stall_cnt", 32'(stall_cnt), 3);
        chk("load_m_or_e", 32'(en_log[8]), 32'b000011);
        chk("load_retire_cycle", (ret_log.size() > 0) ? ret_log[0] : -1, 8);

        // JUMP, BRANCH, STORE back to back
        do_reset();
        for (int i = 0; i < 10; i++) step(1, 1, (i <= 2) ? 4 : (i <= 5) ? 3 : 2, 0, 0);
        step(0, 1, 0, 0, 0);
        chk("seq_retire_count", ret_log.size(), 3);
        chk("seq_retire_0", (ret_log.size() > 0) ? ret_log[0] : -1, 2);
        chk("seq_retire_1", (ret_log.size() > 1) ? ret_log[1] : -1, 5);
        chk("seq_retire_2", (ret_log.size() > 2) ? ret_log[2] : -1, 9);
        chk("seq_we_cycles", we_log.size(), 1);
        chk("seq_we_at", (we_log.size() > 0) ? we_log[0] : -1, 9);
        chk("seq_cycle_cnt", 32'(cycle_cnt), 9);

        // Fetch watchdog expiry
        do_reset();
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("timeout_err", 32'(err), 1);
        chk("timeout_imem_req", 32'(imem_req), 0);
        step(1, 1, 0, 0, 0);
        chk("timeout_cycle_cnt_frozen", 32'(cycle_cnt), 4);

        // Ready on the last permitted wait cycle completes normally
        do_reset();
        for (int i = 0; i < 5; i++) step(i == 4, 1, 0, 0, 0);
        step(1, 1, 0, 0, 0);
        chk("late_ready_decode", 32'(state_enable.decode_enable), 1);
        chk("late_ready_no_err", 32'(err), 0);

        // Halt requested during a LOAD, then resume
        do_reset();
        for (int i = 0; i < 6; i++) step(1, 1, 1, 1, 0);
        step(1, 1, 1, 0, 0);
        chk("halt_halted", 32'(halted), 1);
        chk("halt_cycle_cnt", 32'(cycle_cnt), 5);
        step(1, 1, 0, 0, 0);
        step(1, 1, 0, 0, 1);
        step(1, 1, 0, 0, 0);
        chk("resume_fetch", 32'(imem_req), 1);
        chk("resume_cycle_cnt", 32'(cycle_cnt), 5);

        // Reset in the middle of a MEMORY stage
        do_reset();
        for (int i = 0; i < 9; i++) step(1, !(i == 8), (i <= 4) ? 0 : 1, 0, 0);
        chk("mid_mem_dmem_req", 32'(dmem_req), 1);
        chk("mid_mem_retire_cnt", 32'(retire_cnt), 1);
        async_reset_now();
        step(1, 1, 0, 0, 0);
        chk("post_reset_boot", 32'(imem_req), 0);
        step(1, 1, 0, 0, 0);
        chk("post_reset_fetch", 32'(imem_req), 1);

        // Stall saturation and cycle wrap
        do_reset();
        step(1, 1, 4, 0, 0);
        for (int i = 0; i < 600; i++) step((i % 5) == 3, 1, 4, 0, 0);
        step(0, 1, 4, 0, 0);
        chk("sat_stall_cnt", 32'(stall_cnt), 255);
        chk("wrap_cycle_cnt", 32'(cycle_cnt), 88);
        chk("sat_retire_cnt", 32'(retire_cnt), 120);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                 ($urandom_range(0, 59) == 0) ? 5 + $urandom_range(0, 2) : $urandom_range(0, 4),
                 $urandom_range(0, 9) == 0, $urandom_range(0, 3) == 0);
            if (m_err && $urandom_range(0, 5) == 0) do_reset();
            else if ($urandom_range(0, 299) == 0) async_reset_now();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
